nios_debug_ocimem_arbiter: RTL and testbench
============================================

# nios_debug_ocimem_arbiter

Sequences and shares the on-chip debug RAM (OCI RAM, 2^ADDR_W x 32, synchronous 1-cycle read) between two requesters in the `clk` domain. The first requester is the JTAG debug command path: the `take_action_ocimem_a`, `take_action_ocimem_b` and `take_no_action_ocimem_a` strobes plus `jdo`. The second is the CPU's Avalon debug-memory slave port. The block sits beside the debug-slave sysclk logic and returns JTAG read data through `MonDReg`/`monitor_ready`.

## Interface
- ADDR_W, 8, OCI RAM word-address width
- clk  in  1  system clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- take_action_ocimem_a  in  1  JTAG strobe: load address `jaddr <= jdo[17+ADDR_W:18]`; if `jdo[35]`=1 also queue a read
- take_no_action_ocimem_a  in  1  JTAG strobe: queue read at `jaddr`
- take_action_ocimem_b  in  1  JTAG strobe: queue write of `jdo[34:3]` to `jaddr`, all bytes
- jdo  in  38  JTAG data, sampled only on a strobe cycle
- MonDReg  out  32  last JTAG read data
- monitor_ready  out  1  MonDReg holds data for the most recent JTAG read
- jtag_overrun  out  1  sticky: a JTAG strobe was dropped
- avs_address  in  ADDR_W  CPU word address
- avs_read, avs_write  in  1  CPU request (never both)
- avs_writedata  in  32  CPU write data
- avs_byteenable  in  4  CPU byte enables
- avs_debugaccess  in  1  write permission; writes with 0 complete but do not modify RAM
- avs_readdata  out  32  CPU read data, valid when read and waitrequest=0
- avs_waitrequest  out  1  combinational stall
- ram_addr  out  ADDR_W  RAM address
- ram_wren  out  1  RAM write enable
- ram_byteen  out  4  RAM byte enables
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, one cycle after address

## Operation
- JTAG pending slot: one entry `{op, data}`. A strobe writes the slot; the op becomes eligible the next cycle.
  - A strobe while the slot is full and not granted this cycle is dropped and sets `jtag_overrun`. The overrun flag clears only on reset or on `take_action_ocimem_a`.
  - A strobe in the same cycle the slot is granted is accepted.
  - Any strobe clears `monitor_ready`.
- FSM states: IDLE, J_RD, C_RD.
- Arbitration in IDLE when both pending JTAG and CPU request exist: alternating priority. Register `last_jtag` records the previous winner; the CPU wins if `last_jtag`=1, otherwise JTAG wins.
- JTAG read grant:
  - Cycle 0: `ram_addr=jaddr`, go to J_RD.
  - In J_RD: `MonDReg<=ram_rdata`, `monitor_ready<=1`, `jaddr<=jaddr+1`, go to IDLE.
- JTAG write grant: `ram_wren=1`, `ram_byteen=4'hF`, `ram_wdata=data`, `jaddr<=jaddr+1`. Stay in IDLE.
- CPU write grant: `ram_wren=avs_debugaccess`, `ram_byteen=avs_byteenable`. `avs_waitrequest=0` the same cycle. Stay in IDLE.
- CPU read grant:
  - Drive `ram_addr=avs_address`, `avs_waitrequest=1`, go to C_RD.
  - In C_RD: `avs_waitrequest=0`, `avs_readdata=ram_rdata`, go to IDLE.
- `avs_waitrequest = (avs_read|avs_write) & ~(cpu write granted now | state==C_RD)`.
- `jaddr` wraps modulo 2^ADDR_W (for ADDR_W=8, 255 -> 0).
- `ram_wren` is 0 in every cycle without a write grant.

## Timing
- Reset values: state=IDLE, slot empty, `jaddr`=0, `last_jtag`=0, `MonDReg`=0, `monitor_ready`=0, `jtag_overrun`=0, `avs_readdata`=0 (when not in C_RD), `ram_wren`=0, `ram_addr`=0.
- Reset mid-operation aborts an in-flight read. No RAM write occurs after reset assertion.
- Latency with no contention:
  - Strobe at cycle n: JTAG write lands at n+1; JTAG read gives `monitor_ready`=1 at n+3.
  - CPU write: 1 cycle. CPU read: 2 cycles.
- Worst-case JTAG wait with continuous CPU traffic: one CPU access, i.e. at most 2 extra cycles.
- No grants issue in J_RD or C_RD; requests hold.

## Test plan
- Reset, then `take_action_ocimem_a` with address 0x10 and `jdo[35]`=1 (RAM[0x10]=0xDEADBEEF) -> `MonDReg`=0xDEADBEEF and `monitor_ready`=1 three cycles after the strobe; `jaddr`=0x11.
- Two `take_action_ocimem_b` strobes 4 cycles apart starting at address 0xFF, data 0x1, 0x2 -> RAM[0xFF]=1, RAM[0x00]=2 (wrap).
- CPU continuous reads plus one JTAG read pending -> JTAG granted within 2 cycles. Tie from reset -> JTAG first, then CPU. `avs_readdata` correct for every CPU read.
- Second strobe one cycle after the first while a CPU read holds the arbiter (C_RD) -> `jtag_overrun`=1 and the second op not executed. Next `take_action_ocimem_a` -> `jtag_overrun`=0.
- CPU write 0xAABBCCDD, byteenable 4'b0011, `avs_debugaccess`=1 over 0 -> RAM=0x0000CCDD. Repeat with `avs_debugaccess`=0 -> RAM unchanged, `avs_waitrequest`=0 in the grant cycle.
- Assert `reset_n`=0 during J_RD -> all outputs return to reset values asynchronously; no `monitor_ready` pulse after release.

Source files
------------

// File: rtl/nios_debug_ocimem_arbiter_if.sv
// CPU debug-memory slave bus and OCI RAM port, bundled so the arbiter and its
// environment share one definition of both buses.
interface nios_debug_ocimem_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [3:0]        avs_byteenable;
    logic              avs_debugaccess;
    logic [31:0]       avs_readdata;
    logic              avs_waitrequest;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wren;
    logic [3:0]        ram_byteen;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, avs_debugaccess,
        output avs_readdata, avs_waitrequest,
        output ram_addr, ram_wren, ram_byteen, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, avs_debugaccess,
        input  avs_readdata, avs_waitrequest,
        input  ram_addr, ram_wren, ram_byteen, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/nios_debug_ocimem_arbiter.sv
// Shares the OCI debug RAM between the JTAG command strobes and the CPU's
// Avalon debug slave, with alternating priority and a one-entry JTAG slot.
module nios_debug_ocimem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        take_action_ocimem_a,
    input  logic        take_no_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic [37:0] jdo,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        jtag_overrun,
    output logic [1:0]  dbg_state,
    nios_debug_ocimem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] J_RD = 2'd1;
    localparam logic [1:0] C_RD = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              slot_valid;
    logic              slot_wr;
    logic [31:0]       slot_data;
    logic [ADDR_W-1:0] jaddr;
    logic              last_jtag;

    logic cpu_req;
    logic jtag_win;
    logic cpu_win;
    logic j_rd_grant;
    logic j_wr_grant;
    logic c_rd_grant;
    logic c_wr_grant;
    logic strobe;
    logic accept;
    logic drop;
    logic queue_op;
    logic queue_wr;
    logic unused_jdo;

    // Avalon handshake: a request is held until a cycle with waitrequest=0;
    // that cycle completes it (writes in the grant cycle, reads in C_RD).
    assign cpu_req    = bus.avs_read | bus.avs_write;
    assign jtag_win   = (state == IDLE) & slot_valid & (~cpu_req | ~last_jtag);
    assign cpu_win    = (state == IDLE) & cpu_req & ~jtag_win;
    assign j_rd_grant = jtag_win & ~slot_wr;
    assign j_wr_grant = jtag_win & slot_wr;
    assign c_rd_grant = cpu_win & bus.avs_read;
    assign c_wr_grant = cpu_win & bus.avs_write;

    // The slot frees in its own grant cycle, so a strobe landing then is kept.
    assign strobe   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign accept   = strobe & (~slot_valid | jtag_win);
    assign drop     = strobe & ~accept;
    assign queue_op = take_action_ocimem_a ? jdo[35] : 1'b1;
    assign queue_wr = ~take_action_ocimem_a & take_action_ocimem_b;

    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    assign bus.avs_waitrequest = cpu_req & ~(c_wr_grant | (state == C_RD));
    assign bus.avs_readdata    = (state == C_RD) ? bus.ram_rdata : 32'h0;
    assign dbg_state           = state;

    always_comb begin
        bus.ram_addr   = '0;
        bus.ram_wren   = 1'b0;
        bus.ram_byteen = 4'h0;
        bus.ram_wdata  = 32'h0;
        if (jtag_win) begin
            bus.ram_addr = jaddr;
            if (j_wr_grant) begin
                bus.ram_wren   = 1'b1;
                bus.ram_byteen = 4'hF;
                bus.ram_wdata  = slot_data;
            end
        end else if (cpu_win) begin
            bus.ram_addr = bus.avs_address;
            if (c_wr_grant) begin
                bus.ram_wren   = bus.avs_debugaccess;
                bus.ram_byteen = bus.avs_byteenable;
                bus.ram_wdata  = bus.avs_writedata;
            end
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (j_rd_grant)      state_nxt = J_RD;
                else if (c_rd_grant) state_nxt = C_RD;
                else                 state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            slot_valid    <= 1'b0;
            slot_wr       <= 1'b0;
            slot_data     <= 32'h0;
            jaddr         <= '0;
            last_jtag     <= 1'b0;
            MonDReg       <= 32'h0;
            monitor_ready <= 1'b0;
            jtag_overrun  <= 1'b0;
        end else begin
            state <= state_nxt;

            if (jtag_win)     last_jtag <= 1'b1;
            else if (cpu_win) last_jtag <= 1'b0;

            if (accept && queue_op) begin
                slot_valid <= 1'b1;
                slot_wr    <= queue_wr;
                slot_data  <= jdo[34:3];
            end else if (jtag_win) begin
                slot_valid <= 1'b0;
            end

            // A freshly loaded address takes precedence over the post-access increment.
            if (accept && take_action_ocimem_a) jaddr <= jdo[17+ADDR_W:18];
            else if (j_wr_grant || state == J_RD) jaddr <= jaddr + 1'b1;

            if (state == J_RD) MonDReg <= bus.ram_rdata;

            if (strobe)             monitor_ready <= 1'b0;
            else if (state == J_RD) monitor_ready <= 1'b1;

            if (drop)                                jtag_overrun <= 1'b1;
            else if (accept && take_action_ocimem_a) jtag_overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_nios_debug_ocimem_arbiter.sv
// Bench for the OCI RAM arbiter: behavioural RAM, JTAG/CPU drivers and a
// scoreboard of expected JTAG and CPU read data.
module tb_nios_debug_ocimem_arbiter;
    localparam int K_A  = 0;
    localparam int K_NA = 1;
    localparam int K_B  = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic [37:0] jdo = '0;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        jtag_overrun;
    logic [1:0]  dbg_state;

    logic [31:0] mem [0:255];
    logic [31:0] jtag_exp_q[$];
    logic [31:0] cpu_exp_q[$];
    logic [31:0] exp_v;
    logic        mr_d = 1'b0;
    int          tests_run = 0;
    int          fails = 0;

    nios_debug_ocimem_arbiter_if #(.ADDR_W(8)) bus ();

    nios_debug_ocimem_arbiter #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .jdo                     (jdo),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .jtag_overrun            (jtag_overrun),
        .dbg_state               (dbg_state),
        .bus                     (bus)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Behavioural OCI RAM: old data on read-during-write, byte-enabled writes.
    always @(posedge clk) begin
        bus.ram_rdata <= mem[bus.ram_addr];
        if (bus.ram_wren) begin
            for (int b = 0; b < 4; b++)
                if (bus.ram_byteen[b]) mem[bus.ram_addr][8*b +: 8] = bus.ram_wdata[8*b +: 8];
        end
    end

    // scoreboard
    always @(negedge clk) begin
        if (reset_n) begin
            if (monitor_ready && !mr_d) begin
                tests_run++;
                if (jtag_exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL jtag_sb: unexpected monitor_ready, MonDReg=%h", MonDReg);
                end else begin
                    exp_v = jtag_exp_q.pop_front();
                    if (MonDReg !== exp_v) begin
                        fails++;
                        $display("FAIL jtag_sb: MonDReg got %h expected %h", MonDReg, exp_v);
                    end
                end
            end
            if (bus.avs_read && !bus.avs_waitrequest) begin
                tests_run++;
                if (cpu_exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL cpu_sb: unexpected read completion, data=%h", bus.avs_readdata);
                end else begin
                    exp_v = cpu_exp_q.pop_front();
                    if (bus.avs_readdata !== exp_v) begin
                        fails++;
                        $display("FAIL cpu_sb: avs_readdata got %h expected %h", bus.avs_readdata, exp_v);
                    end
                end
            end
        end
        mr_d = monitor_ready;
    end

    // driver tasks
    function automatic logic [37:0] jdo_addr(input logic [7:0] a, input logic rd);
        logic [37:0] v;
        v        = '0;
        v[25:18] = a;
        v[35]    = rd;
        return v;
    endfunction

    function automatic logic [37:0] jdo_data(input logic [31:0] d);
        logic [37:0] v;
        v       = '0;
        v[34:3] = d;
        return v;
    endfunction

    task automatic cpu_idle();
        bus.avs_read        = 1'b0;
        bus.avs_write       = 1'b0;
        bus.avs_address     = '0;
        bus.avs_writedata   = '0;
        bus.avs_byteenable  = '0;
        bus.avs_debugaccess = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
        cpu_idle();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // One-cycle strobe; returns 1ns into the cycle after the strobe.
    task automatic strobe(input int kind, input logic [37:0] j);
        jdo = j;
        take_action_ocimem_a    = (kind == K_A);
        take_no_action_ocimem_a = (kind == K_NA);
        take_action_ocimem_b    = (kind == K_B);
        @(posedge clk);
        #1;
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a, input logic [31:0] exp);
        bit done;
        done = 0;
        cpu_exp_q.push_back(exp);
        bus.avs_read    = 1'b1;
        bus.avs_address = a;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (!bus.avs_waitrequest) done = 1;
            @(posedge clk);
            #1;
        end
        bus.avs_read = 1'b0;
        if (!done) begin
            tests_run++;
            fails++;
            $display("FAIL cpu_read_timeout: addr %h got no completion, required within 20 cycles", a);
        end
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                             input logic dbg, output int waits);
        bit done;
        done  = 0;
        waits = 0;
        bus.avs_write       = 1'b1;
        bus.avs_address     = a;
        bus.avs_writedata   = d;
        bus.avs_byteenable  = be;
        bus.avs_debugaccess = dbg;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (!bus.avs_waitrequest) done = 1;
            else waits++;
            @(posedge clk);
            #1;
        end
        cpu_idle();
        if (!done) begin
            tests_run++;
            fails++;
            $display("FAIL cpu_write_timeout: addr %h got no completion, required within 20 cycles", a);
        end
    endtask

    // tests
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        tests_run++; if (MonDReg !== 32'h0) begin fails++; $display("FAIL rst_mondreg: got %h expected 0", MonDReg); end
        tests_run++; if (monitor_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b expected 0", monitor_ready); end
        tests_run++; if (jtag_overrun !== 1'b0) begin fails++; $display("FAIL rst_overrun: got %b expected 0", jtag_overrun); end
        tests_run++; if (bus.avs_readdata !== 32'h0) begin fails++; $display("FAIL rst_readdata: got %h expected 0", bus.avs_readdata); end
        tests_run++; if (bus.ram_wren !== 1'b0) begin fails++; $display("FAIL rst_wren: got %b expected 0", bus.ram_wren); end
        tests_run++; if (bus.ram_addr !== 8'h0) begin fails++; $display("FAIL rst_addr: got %h expected 0", bus.ram_addr); end
        tests_run++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_jtag_read();
        mem[8'h10] = 32'hDEADBEEF;
        jtag_exp_q.push_back(32'hDEADBEEF);
        strobe(K_A, jdo_addr(8'h10, 1'b1));
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++; if (monitor_ready !== 1'b0) begin fails++; $display("FAIL jrd_early: monitor_ready got %b expected 0 at n+2", monitor_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++; if (monitor_ready !== 1'b1) begin fails++; $display("FAIL jrd_ready: monitor_ready got %b expected 1 at n+3", monitor_ready); end
        tests_run++; if (MonDReg !== 32'hDEADBEEF) begin fails++; $display("FAIL jrd_data: MonDReg got %h expected deadbeef", MonDReg); end
        @(posedge clk); #1;
        // follow-on read uses the auto-incremented address 0x11
        mem[8'h11] = 32'h0BADF00D;
        jtag_exp_q.push_back(32'h0BADF00D);
        strobe(K_NA, '0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_jtag_write_wrap();
        strobe(K_A, jdo_addr(8'hFF, 1'b0));
        @(posedge clk); #1;
        strobe(K_B, jdo_data(32'h1));
        @(negedge clk);
        tests_run++;
        if (bus.ram_wren !== 1'b1 || bus.ram_addr !== 8'hFF || bus.ram_wdata !== 32'h1) begin
            fails++;
            $display("FAIL jwr_first: wren=%b addr=%h wdata=%h expected 1/ff/00000001", bus.ram_wren, bus.ram_addr, bus.ram_wdata);
        end
        repeat (3) begin @(posedge clk); #1; end
        strobe(K_B, jdo_data(32'h2));
        @(negedge clk);
        tests_run++; if (bus.ram_addr !== 8'h00) begin fails++; $display("FAIL jwr_wrap_addr: ram_addr got %h expected 00", bus.ram_addr); end
        @(posedge clk); #1;
        tests_run++; if (mem[8'hFF] !== 32'h1) begin fails++; $display("FAIL jwr_ram_ff: got %h expected 00000001", mem[8'hFF]); end
        tests_run++; if (mem[8'h00] !== 32'h2) begin fails++; $display("FAIL jwr_ram_00: got %h expected 00000002", mem[8'h00]); end
    endtask

    task automatic test_fairness();
        int  lat;
        bit  got;
        do_reset();
        jtag_exp_q.push_back(mem[0]);
        strobe(K_NA, '0);
        fork
            begin
                for (int i = 0; i < 10; i++) cpu_read(8'(32 + i), mem[32 + i]);
            end
            begin
                @(negedge clk);
                tests_run++; if (bus.ram_addr !== 8'h00) begin fails++; $display("FAIL tie_jtag_first: ram_addr got %h expected 00", bus.ram_addr); end
                @(negedge clk);
                @(negedge clk);
                tests_run++; if (bus.ram_addr !== 8'h20) begin fails++; $display("FAIL tie_cpu_second: ram_addr got %h expected 20", bus.ram_addr); end
                repeat (3) @(posedge clk);
                #1;
                jtag_exp_q.push_back(mem[1]);
                strobe(K_NA, '0);
                lat = 0;
                got = 0;
                for (int k = 1; k <= 10 && !got; k++) begin
                    @(negedge clk);
                    if (monitor_ready) begin got = 1; lat = k; end
                    else begin @(posedge clk); #1; end
                end
                tests_run++;
                if (!got || lat > 5) begin
                    fails++;
                    $display("FAIL jtag_wait_bound: ready after %0d cycles (got=%0d), required <= 5", lat, got);
                end
            end
        join
        cpu_idle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_overrun();
        logic [31:0] orig40;
        logic [31:0] orig41;
        strobe(K_A, jdo_addr(8'h40, 1'b0));
        repeat (2) begin @(posedge clk); #1; end
        orig40 = mem[8'h40];
        orig41 = mem[8'h41];
        jtag_exp_q.push_back(orig40);
        cpu_exp_q.push_back(mem[8'h50]);
        bus.avs_read            = 1'b1;
        bus.avs_address         = 8'h50;
        take_no_action_ocimem_a = 1'b1;
        @(posedge clk); #1;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b1;
        jdo                     = jdo_data(32'h12345678);
        @(negedge clk);
        tests_run++; if (dbg_state !== 2'd2) begin fails++; $display("FAIL ovr_crd: state got %0d expected 2", dbg_state); end
        @(posedge clk); #1;
        take_action_ocimem_b = 1'b0;
        bus.avs_read         = 1'b0;
        @(negedge clk);
        tests_run++; if (jtag_overrun !== 1'b1) begin fails++; $display("FAIL ovr_set: jtag_overrun got %b expected 1", jtag_overrun); end
        repeat (6) begin @(posedge clk); #1; end
        tests_run++; if (mem[8'h40] !== orig40) begin fails++; $display("FAIL ovr_no_wr40: got %h expected %h", mem[8'h40], orig40); end
        tests_run++; if (mem[8'h41] !== orig41) begin fails++; $display("FAIL ovr_no_wr41: got %h expected %h", mem[8'h41], orig41); end
        tests_run++; if (jtag_overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky: jtag_overrun got %b expected 1", jtag_overrun); end
        strobe(K_A, jdo_addr(8'h60, 1'b0));
        @(negedge clk);
        tests_run++; if (jtag_overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear: jtag_overrun got %b expected 0", jtag_overrun); end
        @(posedge clk); #1;
    endtask

    task automatic test_cpu_write();
        int waits;
        mem[8'h30] = 32'h0;
        cpu_write(8'h30, 32'hAABBCCDD, 4'b0011, 1'b1, waits);
        tests_run++; if (waits != 0) begin fails++; $display("FAIL cwr_wait: stalled %0d cycles expected 0", waits); end
        tests_run++; if (mem[8'h30] !== 32'h0000CCDD) begin fails++; $display("FAIL cwr_bytes: got %h expected 0000ccdd", mem[8'h30]); end
        cpu_read(8'h30, 32'h0000CCDD);
        cpu_write(8'h30, 32'h11223344, 4'hF, 1'b0, waits);
        tests_run++; if (waits != 0) begin fails++; $display("FAIL cwr_nodbg_wait: stalled %0d cycles expected 0", waits); end
        tests_run++; if (mem[8'h30] !== 32'h0000CCDD) begin fails++; $display("FAIL cwr_nodbg: got %h expected 0000ccdd", mem[8'h30]); end
        cpu_read(8'h30, 32'h0000CCDD);
        for (int i = 0; i < 4; i++) begin
            logic [7:0]  a;
            logic [31:0] d;
            a = 8'($urandom_range(128, 191));
            d = $urandom;
            cpu_write(a, d, 4'hF, 1'b1, waits);
            cpu_read(a, d);
        end
    endtask

    task automatic test_reset_mid_read();
        int pulses;
        strobe(K_A, jdo_addr(8'h70, 1'b1));
        @(posedge clk); #1;
        tests_run++; if (dbg_state !== 2'd1) begin fails++; $display("FAIL mid_jrd: state got %0d expected 1", dbg_state); end
        reset_n = 1'b0;
        #1;
        tests_run++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL mid_state: got %0d expected 0", dbg_state); end
        tests_run++; if (MonDReg !== 32'h0) begin fails++; $display("FAIL mid_mondreg: got %h expected 0", MonDReg); end
        tests_run++; if (monitor_ready !== 1'b0) begin fails++; $display("FAIL mid_ready: got %b expected 0", monitor_ready); end
        tests_run++; if (bus.ram_wren !== 1'b0 || bus.ram_addr !== 8'h0) begin fails++; $display("FAIL mid_ram: wren=%b addr=%h expected 0/00", bus.ram_wren, bus.ram_addr); end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (monitor_ready) pulses++;
        end
        tests_run++; if (pulses != 0) begin fails++; $display("FAIL mid_no_pulse: monitor_ready high %0d cycles expected 0", pulses); end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        cpu_idle();
        test_reset();
        test_jtag_read();
        test_jtag_write_wrap();
        test_fairness();
        test_overrun();
        test_cpu_write();
        test_reset_mid_read();
        repeat (3) @(posedge clk);
        tests_run++; if (jtag_exp_q.size() != 0) begin fails++; $display("FAIL jtag_q_drain: %0d reads outstanding expected 0", jtag_exp_q.size()); end
        tests_run++; if (cpu_exp_q.size() != 0) begin fails++; $display("FAIL cpu_q_drain: %0d reads outstanding expected 0", cpu_exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
